// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the raster timing controller: 1024x768@60 default
//   timing, helpers that derive the line/frame totals, and the run/stop
//   state encoding.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 32'd1024;
    localparam int DEF_H_FP     = 32'd24;
    localparam int DEF_H_SYNC   = 32'd136;
    localparam int DEF_H_BP     = 32'd160;
    localparam int DEF_V_ACTIVE = 32'd768;
    localparam int DEF_V_FP     = 32'd3;
    localparam int DEF_V_SYNC   = 32'd6;
    localparam int DEF_V_BP     = 32'd29;
    localparam int DEF_H_POL    = 32'd0;
    localparam int DEF_V_POL    = 32'd0;
    localparam int DEF_HW       = 32'd11;
    localparam int DEF_VW       = 32'd10;

    // Raster state encoding.
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] STOPPING = 2'd2;

    // Pixel clocks per line.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Lines per frame.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// wrap_counter
//   Modulo-(MAX+1) up-counter used for both raster axes.
//   clk   : clock
//   rst_n : asynchronous active-low reset (q -> 0)
//   clr   : synchronous clear, overrides inc
//   inc   : advance by one this clock
//   q     : current count (registered)
//   wrap  : q is at MAX and is advancing, so it returns to 0 on this clock.
//           Combinational, so a cascaded counter steps on the same clock.
module wrap_counter #(
    parameter int WIDTH = 32'd4,
    parameter int MAX   = 32'd15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(32'd1);

    // Carry out to the next axis.
    always_comb begin
        wrap = inc && !clr && (q == MAX_Q);
    end

    // Count state; the compare against MAX keeps q inside WIDTH bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= ZERO_Q;
        end else if (clr) begin
            q <= ZERO_Q;
        end else if (inc) begin
            if (q == MAX_Q) begin
                q <= ZERO_Q;
            end else begin
                q <= q + ONE_Q;
            end
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing controller: pixel/line counters plus raw hsync/vsync/blank
//   strobes, with a run/stop handshake that only stops at a frame boundary.
//   clk         : clock
//   rst_n       : asynchronous active-low reset
//   en          : pixel tick; counters advance only when en=1
//   run         : level request to run the raster
//   hcount      : current pixel column
//   vcount      : current line
//   hsync/vsync : sync strobes at H_POL/V_POL asserted level
//   blank       : 1 outside the active area (and whenever idle)
//   line_start  : one-clock pulse when hcount becomes 0 while running
//   frame_start : one-clock pulse when (hcount,vcount) becomes (0,0)
//   busy        : raster is running or finishing its last frame
// All outputs are registered on the same clock as the counters; the strobes
// are decoded from the counters' next values so they line up with zero lag.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_POL    = DEF_H_POL,
    parameter int V_POL    = DEF_V_POL,
    parameter int HW       = DEF_HW,
    parameter int VW       = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          run,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Sync windows are stored as inclusive first/last so no bound ever has
    // to represent H_TOTAL itself in HW bits.
    localparam logic [HW-1:0] H_ACT_Q        = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_FIRST_Q = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_LAST_Q  = HW'(H_ACTIVE + H_FP + H_SYNC - 32'd1);
    localparam logic [VW-1:0] V_ACT_Q        = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_FIRST_Q = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_LAST_Q  = VW'(V_ACTIVE + V_FP + V_SYNC - 32'd1);
    localparam logic [HW-1:0] H_ZERO_Q       = {HW{1'b0}};
    localparam logic [VW-1:0] V_ZERO_Q       = {VW{1'b0}};
    localparam logic [HW-1:0] H_ONE_Q        = HW'(32'd1);
    localparam logic [VW-1:0] V_ONE_Q        = VW'(32'd1);
    localparam logic          HS_ON          = 1'(H_POL);
    localparam logic          VS_ON          = 1'(V_POL);

    if ((64'd1 << HW) < 64'(H_TOTAL)) begin : g_hw_too_small
        $error("vga_timing_gen: HW too small for H_TOTAL");
    end
    if ((64'd1 << VW) < 64'(V_TOTAL)) begin : g_vw_too_small
        $error("vga_timing_gen: VW too small for V_TOTAL");
    end

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          counting_s;
    logic          cnt_inc_s;
    logic          cnt_clr_s;
    logic          start_s;
    logic          h_wrap_s;
    logic          v_wrap_s;
    logic [HW-1:0] h_nxt_s;
    logic [VW-1:0] v_nxt_s;
    logic          busy_nxt_s;
    logic          hsync_nxt_s;
    logic          vsync_nxt_s;
    logic          blank_nxt_s;
    logic          line_start_nxt_s;
    logic          frame_start_nxt_s;

    // Counters advance only while a raster is in progress; idle holds them at 0.
    always_comb begin
        counting_s = (state_r == RUN) || (state_r == STOPPING);
        cnt_inc_s  = counting_s && en;
        cnt_clr_s  = !counting_s;
    end

    wrap_counter #(
        .WIDTH (HW),
        .MAX   (H_TOTAL - 32'd1)
    ) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .q     (hcount),
        .wrap  (h_wrap_s)
    );

    wrap_counter #(
        .WIDTH (VW),
        .MAX   (V_TOTAL - 32'd1)
    ) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .inc   (h_wrap_s),
        .q     (vcount),
        .wrap  (v_wrap_s)
    );

    // Next counter values, mirroring what the counters will load this clock.
    always_comb begin
        h_nxt_s = hcount;
        v_nxt_s = vcount;
        if (cnt_clr_s) begin
            h_nxt_s = H_ZERO_Q;
            v_nxt_s = V_ZERO_Q;
        end else if (cnt_inc_s) begin
            if (h_wrap_s) begin
                h_nxt_s = H_ZERO_Q;
                if (v_wrap_s) begin
                    v_nxt_s = V_ZERO_Q;
                end else begin
                    v_nxt_s = vcount + V_ONE_Q;
                end
            end else begin
                h_nxt_s = hcount + H_ONE_Q;
            end
        end else begin
            h_nxt_s = hcount;
            v_nxt_s = vcount;
        end
    end

    // Run/stop sequencing; a stop only lands once the last pixel of a frame ticks.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (run && en) begin
                    state_nxt_s = RUN;
                    start_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (!run) begin
                    state_nxt_s = STOPPING;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            STOPPING: begin
                if (run) begin
                    state_nxt_s = RUN;
                end else if (v_wrap_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOPPING;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Strobe decode from next counter values; idle forces inactive levels.
    always_comb begin
        busy_nxt_s = (state_nxt_s != IDLE);
        if (busy_nxt_s) begin
            hsync_nxt_s = ((h_nxt_s >= H_SYNC_FIRST_Q) && (h_nxt_s <= H_SYNC_LAST_Q)) ? HS_ON : ~HS_ON;
            vsync_nxt_s = ((v_nxt_s >= V_SYNC_FIRST_Q) && (v_nxt_s <= V_SYNC_LAST_Q)) ? VS_ON : ~VS_ON;
            blank_nxt_s = !((h_nxt_s < H_ACT_Q) && (v_nxt_s < V_ACT_Q));
            line_start_nxt_s  = start_s || (cnt_inc_s && (h_nxt_s == H_ZERO_Q));
            frame_start_nxt_s = start_s || (cnt_inc_s && (h_nxt_s == H_ZERO_Q) && (v_nxt_s == V_ZERO_Q));
        end else begin
            hsync_nxt_s       = ~HS_ON;
            vsync_nxt_s       = ~VS_ON;
            blank_nxt_s       = 1'b1;
            line_start_nxt_s  = 1'b0;
            frame_start_nxt_s = 1'b0;
        end
    end

    // State and registered strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            blank       <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hsync       <= hsync_nxt_s;
            vsync       <= vsync_nxt_s;
            blank       <= blank_nxt_s;
            line_start  <= line_start_nxt_s;
            frame_start <= frame_start_nxt_s;
            busy        <= busy_nxt_s;
        end
    end

endmodule
